// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared arbiter state encoding, mode constants and index helper
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam int RR_MODE_FIXED = 0;
  localparam int RR_MODE_ROUND = 1;

  // Modular add for indices already in 0..n-1 and an offset below n.
  function automatic int wrap_add(input int base, input int offs, input int n);
    int s;
    s = base + offs;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational winner select, round-robin from ptr or lowest index first
module rr_pick
  import cpu_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     win
);

  logic found;
  int   base;
  int   idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    base  = 0;
    // An out-of-range pointer falls back to index 0 so the search stays in bounds.
    if (mode && (int'(ptr) < N)) begin
      base = int'(ptr);
    end
    for (int k = 0; k < N; k++) begin
      idx = wrap_add(base, k, N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_arbiter.sv
// rtl/line_arbiter.sv - N-port cache line arbiter in front of a single MMU port
module line_arbiter
  import cpu_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 256,
  parameter int PENT_W    = 32,
  parameter int RR_MODE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [N_MASTERS*LINE_W-1:0] m_data_i,
  input  logic [N_MASTERS-1:0]        m_rd_i,
  input  logic [N_MASTERS-1:0]        m_we_i,
  output logic [LINE_W-1:0]           m_data_o,
  output logic [PENT_W-1:0]           m_page_ent_o,
  output logic [N_MASTERS-1:0]        m_ack_o,
  output logic [N_MASTERS-1:0]        m_hw_page_fault_o,
  output logic [ADDR_W-1:0]           addr_o,
  output logic [LINE_W-1:0]           data_o,
  output logic                        rd_o,
  output logic                        we_o,
  input  logic [LINE_W-1:0]           data_i,
  input  logic [PENT_W-1:0]           page_ent_i,
  input  logic                        ack_i,
  input  logic                        hw_page_fault_i,
  output logic [N_MASTERS-1:0]        grant_o
);

  localparam int   PTR_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam logic MODE_BIT = (RR_MODE == RR_MODE_ROUND);

  arb_state_t           state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     owner;
  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] win;
  logic [PTR_W-1:0]     win_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic [LINE_W-1:0]    sel_data;
  logic                 sel_rd;
  logic                 sel_we;
  logic                 done;
  logic                 resp_ok;
  logic                 resp_flt;

  assign req = m_rd_i | m_we_i;

  rr_pick #(
    .N     (N_MASTERS),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr),
    .mode (MODE_BIT),
    .win  (win)
  );

  always_comb begin
    win_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_rd   = 1'b0;
    sel_we   = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (win[i]) begin
        win_idx  = PTR_W'(i);
        sel_addr = m_addr_i[i*ADDR_W +: ADDR_W];
        sel_data = m_data_i[i*LINE_W +: LINE_W];
        sel_rd   = m_rd_i[i];
        sel_we   = m_we_i[i];
      end
    end
  end

  assign done = ack_i | hw_page_fault_i;

  // RELEASE is the mandatory idle bus cycle; it may launch the next owner so the gap is exactly one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ARB_IDLE;
      ptr     <= '0;
      owner   <= '0;
      addr_o  <= '0;
      data_o  <= '0;
      rd_o    <= 1'b0;
      we_o    <= 1'b0;
      grant_o <= '0;
    end else begin
      case (state)
        ARB_IDLE, ARB_RELEASE: begin
          if (|req) begin
            addr_o  <= sel_addr;
            data_o  <= sel_data;
            we_o    <= sel_we;
            rd_o    <= sel_rd & ~sel_we;
            grant_o <= win;
            owner   <= win_idx;
            state   <= ARB_BUSY;
          end else begin
            state   <= ARB_IDLE;
          end
        end
        ARB_BUSY: begin
          if (done) begin
            rd_o    <= 1'b0;
            we_o    <= 1'b0;
            grant_o <= '0;
            ptr     <= PTR_W'(wrap_add(int'(owner), 1, N_MASTERS));
            state   <= ARB_RELEASE;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // A fault overrides a simultaneous ack; grant_o is one-hot so at most one pulse is raised.
  assign resp_flt = (state == ARB_BUSY) & hw_page_fault_i;
  assign resp_ok  = (state == ARB_BUSY) & ack_i & ~hw_page_fault_i;

  assign m_ack_o           = resp_ok  ? grant_o : '0;
  assign m_hw_page_fault_o = resp_flt ? grant_o : '0;
  assign m_data_o          = resp_ok  ? data_i     : '0;
  assign m_page_ent_o      = resp_ok  ? page_ent_i : '0;

endmodule

// File: tb/tb_line_arbiter.sv
// tb/tb_line_arbiter.sv - scoreboard bench for line_arbiter, N=2 RR, N=4 RR and N=4 fixed
module tb_line_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   qa[$];
  int   qr[$];
  int   qf[$];

  logic [63:0]  a_addr;
  logic [511:0] a_wdata;
  logic [1:0]   a_rd, a_we, a_ack, a_flt, a_grant;
  logic [255:0] a_mdata, a_data_o, a_dn_data;
  logic [31:0]  a_pent, a_addr_o, a_dn_pent;
  logic         a_rd_o, a_we_o, a_dn_ack, a_dn_flt;

  logic [63:0] r_addr, r_wdata, f_addr, f_wdata;
  logic [3:0]  r_rd, r_we, r_ack, r_flt, r_grant;
  logic [3:0]  f_rd, f_we, f_ack, f_flt, f_grant;
  logic [15:0] r_mdata, r_addr_o, r_data_o, r_dn_data;
  logic [15:0] f_mdata, f_addr_o, f_data_o, f_dn_data;
  logic [7:0]  r_pent, r_dn_pent, f_pent, f_dn_pent;
  logic        r_rd_o, r_we_o, r_dn_ack, r_dn_flt;
  logic        f_rd_o, f_we_o, f_dn_ack, f_dn_flt;

  line_arbiter #(.N_MASTERS(2), .RR_MODE(1)) u_a (
    .clk(clk), .rst(rst_n), .m_addr_i(a_addr), .m_data_i(a_wdata), .m_rd_i(a_rd), .m_we_i(a_we),
    .m_data_o(a_mdata), .m_page_ent_o(a_pent), .m_ack_o(a_ack), .m_hw_page_fault_o(a_flt),
    .addr_o(a_addr_o), .data_o(a_data_o), .rd_o(a_rd_o), .we_o(a_we_o),
    .data_i(a_dn_data), .page_ent_i(a_dn_pent), .ack_i(a_dn_ack), .hw_page_fault_i(a_dn_flt),
    .grant_o(a_grant)
  );

  line_arbiter #(.N_MASTERS(4), .ADDR_W(16), .LINE_W(16), .PENT_W(8), .RR_MODE(1)) u_r (
    .clk(clk), .rst(rst_n), .m_addr_i(r_addr), .m_data_i(r_wdata), .m_rd_i(r_rd), .m_we_i(r_we),
    .m_data_o(r_mdata), .m_page_ent_o(r_pent), .m_ack_o(r_ack), .m_hw_page_fault_o(r_flt),
    .addr_o(r_addr_o), .data_o(r_data_o), .rd_o(r_rd_o), .we_o(r_we_o),
    .data_i(r_dn_data), .page_ent_i(r_dn_pent), .ack_i(r_dn_ack), .hw_page_fault_i(r_dn_flt),
    .grant_o(r_grant)
  );

  line_arbiter #(.N_MASTERS(4), .ADDR_W(16), .LINE_W(16), .PENT_W(8), .RR_MODE(0)) u_f (
    .clk(clk), .rst(rst_n), .m_addr_i(f_addr), .m_data_i(f_wdata), .m_rd_i(f_rd), .m_we_i(f_we),
    .m_data_o(f_mdata), .m_page_ent_o(f_pent), .m_ack_o(f_ack), .m_hw_page_fault_o(f_flt),
    .addr_o(f_addr_o), .data_o(f_data_o), .rd_o(f_rd_o), .we_o(f_we_o),
    .data_i(f_dn_data), .page_ent_i(f_dn_pent), .ack_i(f_dn_ack), .hw_page_fault_i(f_dn_flt),
    .grant_o(f_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response monitors pop the scoreboard whenever any completion or fault pulse appears.
  always @(negedge clk) begin
    if (rst_n && (a_ack != 0 || a_flt != 0)) begin
      if (qa.size() == 0) chk("a_unexpected", {a_flt, a_ack}, 0);
      else chk("a_resp", {a_flt, a_ack}, qa.pop_front());
      if (a_ack != 0) begin
        chk("a_mdata", a_mdata, a_dn_data);
        chk("a_pent", a_pent, a_dn_pent);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (r_ack != 0 || r_flt != 0)) begin
      if (qr.size() == 0) chk("r_unexpected", {r_flt, r_ack}, 0);
      else chk("r_resp", {r_flt, r_ack}, qr.pop_front());
      if (r_ack != 0) chk("r_mdata", r_mdata, r_dn_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n && (f_ack != 0 || f_flt != 0)) begin
      if (qf.size() == 0) chk("f_unexpected", {f_flt, f_ack}, 0);
      else chk("f_resp", {f_flt, f_ack}, qf.pop_front());
      if (f_ack != 0) chk("f_mdata", f_mdata, f_dn_data);
    end
  end

  task automatic a_wait(input int idx, input logic [31:0] addr, input logic we);
    int n = 0;
    while (!(a_rd_o || a_we_o) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("a_timeout", n, 0);
    chk("a_grant", a_grant, 2'b01 << idx);
    chk("a_addr", a_addr_o, addr);
    chk("a_we", a_we_o, we);
    chk("a_rd", a_rd_o, !we);
  endtask

  task automatic a_resp(input int idx, input logic flt);
    @(posedge clk);
    #1;
    a_dn_data = {8{$urandom()}};
    a_dn_pent = $urandom();
    a_dn_ack  = 1'b1;
    a_dn_flt  = flt;
    qa.push_back(flt ? (4 << idx) : (1 << idx));
    @(negedge clk);
    @(posedge clk);
    #1;
    a_dn_ack = 1'b0;
    a_dn_flt = 1'b0;
  endtask

  task automatic q_wait(input bit fx, input int idx);
    int    n = 0;
    string pfx;
    pfx = fx ? "f" : "r";
    while (!(fx ? f_rd_o : r_rd_o) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({pfx, "_timeout"}, n, 0);
    chk({pfx, "_grant"}, fx ? f_grant : r_grant, 4'b0001 << idx);
    chk({pfx, "_addr"}, fx ? f_addr_o : r_addr_o, 16'h100 * (idx + 1));
  endtask

  task automatic q_resp(input bit fx, input int idx);
    @(posedge clk);
    #1;
    if (fx) begin
      f_dn_data = 16'($urandom());
      f_dn_ack  = 1'b1;
      qf.push_back(1 << idx);
    end else begin
      r_dn_data = 16'($urandom());
      r_dn_ack  = 1'b1;
      qr.push_back(1 << idx);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    f_dn_ack = 1'b0;
    r_dn_ack = 1'b0;
  endtask

  initial begin
    logic [255:0] wline;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a_addr = {32'h0000_2000, 32'h0000_1000};
    a_wdata = '0; a_rd = '0; a_we = '0;
    a_dn_data = '0; a_dn_pent = '0; a_dn_ack = 1'b0; a_dn_flt = 1'b0;
    r_addr = {16'h400, 16'h300, 16'h200, 16'h100};
    f_addr = r_addr;
    r_wdata = '0; r_rd = '0; r_we = '0; r_dn_data = '0; r_dn_pent = '0; r_dn_ack = 1'b0; r_dn_flt = 1'b0;
    f_wdata = '0; f_rd = '0; f_we = '0; f_dn_data = '0; f_dn_pent = '0; f_dn_ack = 1'b0; f_dn_flt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_ctl", {a_rd_o, a_we_o, a_grant, a_ack, a_flt}, 0);
    chk("rst_a_addr", a_addr_o, 0);
    chk("rst_r_ctl", {r_rd_o, r_we_o, r_grant}, 0);
    chk("rst_f_ctl", {f_rd_o, f_we_o, f_grant}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_a", {a_rd_o, a_we_o, a_grant}, 0);

    // Two simultaneous readers from reset: 0 then 1 with a single idle cycle between.
    a_rd = 2'b11;
    @(negedge clk);
    chk("first_lat_rd", a_rd_o, 1'b1);
    a_wait(0, 32'h0000_1000, 1'b0);
    a_resp(0, 1'b0);
    a_rd[0] = 1'b0;
    @(negedge clk);
    chk("gap_rd_low", a_rd_o, 1'b0);
    @(negedge clk);
    chk("gap_rd_high", a_rd_o, 1'b1);
    a_wait(1, 32'h0000_2000, 1'b0);
    a_resp(1, 1'b0);
    a_rd[1] = 1'b0;

    // Write whose request drops mid-transaction keeps the registered command.
    wline = {8{32'h5a5a_0f0f}};
    a_wdata[255:0] = wline;
    a_we[0] = 1'b1;
    a_wait(0, 32'h0000_1000, 1'b1);
    chk("a_wdata", a_data_o, wline);
    a_we[0] = 1'b0;
    a_addr[31:0] = 32'hdead_0000;
    a_wdata[255:0] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_we", a_we_o, 1'b1);
      chk("hold_addr", a_addr_o, 32'h0000_1000);
    end
    a_resp(0, 1'b0);
    a_addr[31:0] = 32'h0000_1000;

    // Fault and ack together on master 1: fault wins.
    a_rd[1] = 1'b1;
    a_wait(1, 32'h0000_2000, 1'b0);
    a_resp(1, 1'b1);
    a_rd[1] = 1'b0;

    // Move ptr to 1, start master 1, then reset mid-transaction.
    a_rd[0] = 1'b1;
    a_wait(0, 32'h0000_1000, 1'b0);
    a_resp(0, 1'b0);
    a_rd = 2'b10;
    a_wait(1, 32'h0000_2000, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    a_dn_ack = 1'b1;
    a_rd = 2'b11;
    #1;
    chk("rst_busy_ctl", {a_rd_o, a_we_o, a_grant, a_ack, a_flt}, 0);
    chk("rst_busy_addr", a_addr_o, 0);
    chk("rst_busy_mdata", a_mdata, 0);
    chk("rst_busy_pent", a_pent, 0);
    @(posedge clk);
    #1;
    a_dn_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_wait(0, 32'h0000_1000, 1'b0);
    a_resp(0, 1'b0);
    a_rd = 2'b00;

    // N=4 round-robin, all four holding: 0,1,2,3,0.
    r_rd = 4'hf;
    for (int k = 0; k < 5; k++) begin
      q_wait(1'b0, k % 4);
      q_resp(1'b0, k % 4);
    end
    r_rd = 4'h0;

    // N=4 fixed priority, masters 1 and 3: 1 keeps winning until it lets go.
    f_rd = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      q_wait(1'b1, 1);
      q_resp(1'b1, 1);
    end
    f_rd[1] = 1'b0;
    q_wait(1'b1, 3);
    q_resp(1'b1, 3);
    f_rd = 4'h0;

    repeat (4) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qr_drained", qr.size(), 0);
    chk("qf_drained", qf.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
